// File: rtl/lc4_fetch_queue.sv
// lc4_fetch_queue: LC4 instruction fetch front end.
// Each issue fetches a PC / PC+1 pair over the two memory read ports, tracks
// the pair across a fixed memory latency, and pushes the returned words into
// a FIFO that decode drains over a valid/ready handshake. A redirect loads a
// new PC, empties the FIFO and retires in-flight pairs via an epoch tag.
// Optional feature: define FETCH_PERF_CNT_EN to add the stall_cycles counter.
module lc4_fetch_queue #(
    parameter logic [15:0] RESET_PC    = 16'h8200,
    parameter int          MEM_LATENCY = 1,
    parameter int          DEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       gwe,
    output logic [15:0]                i1addr,
    output logic [15:0]                i2addr,
    output logic                       i1re,
    output logic                       i2re,
    input  logic [15:0]                i1in,
    input  logic [15:0]                i2in,
    input  logic                       redirect_valid,
    input  logic [15:0]                redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [15:0]                out_insn,
    output logic [15:0]                out_pc,
    output logic [$clog2(DEPTH):0]     fifo_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = AW + 1;
    // An epoch only has to outlive the redirects that can occur while one pair
    // is in flight (at most MEM_LATENCY-1), so it wraps at 2^EW > that count.
    // For MEM_LATENCY of 1 or 2 this is a single toggling bit.
    localparam int EW   = (MEM_LATENCY < 2) ? 1 : $clog2(MEM_LATENCY);
    localparam int LAST = MEM_LATENCY - 1;

    // Architectural fetch state
    logic [15:0]            r_pc;
    logic [EW-1:0]          r_epoch;

    // Tracking pipe: one {valid, epoch, pc} per latency stage
    logic [MEM_LATENCY-1:0] r_pipe_valid;
    logic [EW-1:0]          r_pipe_epoch [MEM_LATENCY];
    logic [15:0]            r_pipe_pc    [MEM_LATENCY];

    // FIFO storage and bookkeeping
    logic [15:0]            r_fifo_insn [DEPTH];
    logic [15:0]            r_fifo_pc   [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic [15:0]            r_out_insn;
    logic [15:0]            r_out_pc;

    // Per-cycle decisions
    logic [31:0]            w_inflight;
    logic [31:0]            w_used;
    logic                   w_redirect;
    logic                   w_advance;
    logic                   w_issue;
    logic                   w_return;
    logic                   w_push;
    logic                   w_pop;
    logic [AW-1:0]          w_wr_ptr_1;
    logic [AW-1:0]          w_rd_ptr_next;
    logic [CW-1:0]          w_count_next;
    logic [15:0]            w_ret_pc_1;
    logic [15:0]            w_head_insn_next;
    logic [15:0]            w_head_pc_next;

    // Redirect wins over everything; a normal cycle is gwe without redirect
    assign w_redirect = gwe & redirect_valid;
    assign w_advance  = gwe & ~redirect_valid;

    // Count occupied tracking stages, stale ones included, as outstanding pairs
    always_comb begin
        w_inflight = 32'd0;
        for (int k = 0; k < MEM_LATENCY; k++) begin
            w_inflight = w_inflight + {31'd0, r_pipe_valid[k]};
        end
    end

    // Issue only when the FIFO can absorb this pair plus every pair in flight
    assign w_used  = {{(32-CW){1'b0}}, r_count} + (w_inflight << 1);
    assign w_issue = ~rst & w_advance & ((w_used + 32'd2) <= 32'(DEPTH));

    // A pair returns from the last stage only if it belongs to the live stream
    assign w_return   = r_pipe_valid[LAST] & (r_pipe_epoch[LAST] == r_epoch);
    assign w_push     = w_advance & w_return;
    assign w_pop      = w_advance & out_valid & out_ready;
    assign w_ret_pc_1 = r_pipe_pc[LAST] + 16'd1;

    assign w_wr_ptr_1    = r_wr_ptr + AW'(1);
    assign w_rd_ptr_next = r_rd_ptr + {{(AW-1){1'b0}}, w_pop};
    assign w_count_next  = r_count
                         + (w_push ? CW'(2) : CW'(0))
                         - (w_pop  ? CW'(1) : CW'(0));

    // Select the next head entry, forwarding a word written this same cycle
    always_comb begin
        w_head_insn_next = r_fifo_insn[w_rd_ptr_next];
        w_head_pc_next   = r_fifo_pc[w_rd_ptr_next];
        if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
            w_head_insn_next = i1in;
            w_head_pc_next   = r_pipe_pc[LAST];
        end else if (w_push && (w_rd_ptr_next == w_wr_ptr_1)) begin
            w_head_insn_next = i2in;
            w_head_pc_next   = w_ret_pc_1;
        end
    end

    // PC and epoch: redirect starts a new stream, an issue advances one pair
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_epoch <= '0;
        end else if (w_redirect) begin
            r_pc    <= redirect_pc;
            r_epoch <= r_epoch + EW'(1);
        end else if (w_issue) begin
            r_pc    <= r_pc + 16'd2;
        end
    end

    // Tracking pipe shifts on every gwe cycle; stale entries ride out the pipe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < MEM_LATENCY; k++) begin
                r_pipe_valid[k] <= 1'b0;
                r_pipe_epoch[k] <= '0;
                r_pipe_pc[k]    <= '0;
            end
        end else if (gwe) begin
            r_pipe_valid[0] <= w_issue;
            r_pipe_epoch[0] <= r_epoch;
            r_pipe_pc[0]    <= r_pc;
            for (int k = 1; k < MEM_LATENCY; k++) begin
                r_pipe_valid[k] <= r_pipe_valid[k-1];
                r_pipe_epoch[k] <= r_pipe_epoch[k-1];
                r_pipe_pc[k]    <= r_pipe_pc[k-1];
            end
        end
    end

    // FIFO storage: a returning pair lands in two consecutive slots
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_insn[r_wr_ptr]   <= i1in;
            r_fifo_pc[r_wr_ptr]     <= r_pipe_pc[LAST];
            r_fifo_insn[w_wr_ptr_1] <= i2in;
            r_fifo_pc[w_wr_ptr_1]   <= w_ret_pc_1;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the queue outright
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (gwe) begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(2);
            end
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
        end
    end

    // Registered head; an empty FIFO keeps showing the last head values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_insn <= '0;
            r_out_pc   <= '0;
        end else if (w_advance && (w_count_next != '0)) begin
            r_out_insn <= w_head_insn_next;
            r_out_pc   <= w_head_pc_next;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    // Saturating count of live cycles in which decode had nothing to take
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (w_advance && !out_valid && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    assign i1addr     = r_pc;
    assign i2addr     = r_pc + 16'd1;
    assign i1re       = w_issue;
    assign i2re       = w_issue;
    assign out_valid  = (r_count != '0);
    assign fifo_count = r_count;
    assign out_insn   = r_out_insn;
    assign out_pc     = r_out_pc;

endmodule

// File: doc/lc4_fetch_queue.md
Name: lc4_fetch_queue

Overview:
- Instruction fetch front end that drives the two instruction read ports of the LC4 memory block.
- Each fetch issues a PC / PC+1 pair and tracks the requests in flight across a fixed memory read latency.
- Returned words are pushed into a FIFO that is drained by decode over a valid/ready handshake.
- A branch redirect flushes the queue and discards in-flight returns by means of an epoch tag.

Parameters:
- RESET_PC, 16'h8200, PC loaded on reset.
- MEM_LATENCY, 1, cycles from an issue (i1re/i2re high) to valid data on i1in/i2in. Legal range 1..9; set to 9 when the instruction cache delay is built into memory.
- DEPTH, 8, FIFO entries. Must be a power of 2 and at least 4.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- gwe  in  1  global write enable; all state updates are qualified by gwe
- i1addr  out  16  port-1 fetch address (PC)
- i2addr  out  16  port-2 fetch address (PC+1)
- i1re  out  1  port-1 read enable
- i2re  out  1  port-2 read enable
- i1in  in  16  port-1 returned instruction word
- i2in  in  16  port-2 returned instruction word
- redirect_valid  in  1  load a new PC and flush
- redirect_pc  in  16  target PC for a redirect
- out_valid  out  1  FIFO head is valid
- out_ready  in  1  decode accepts the head
- out_insn  out  16  head instruction word
- out_pc  out  16  head instruction address
- fifo_count  out  log2(DEPTH)+1  current occupancy
- stall_cycles  out  32  present only with FETCH_PERF_CNT_EN

Behaviour:
- Reset (asynchronous, active high):
  - pc=RESET_PC, epoch=0, FIFO empty.
  - All in-flight valid bits cleared.
  - Outputs: i1re=i2re=0, out_valid=0, fifo_count=0, i1addr=RESET_PC, i2addr=RESET_PC+1, out_insn=0, out_pc=0.
- gwe low:
  - No register changes; i1re=i2re=0.
  - out_valid and head data still reflect FIFO state, but a pop is not taken even if out_ready=1.
  - redirect_valid is ignored.
- Issue condition: gwe=1, redirect_valid=0, and (DEPTH - fifo_count - 2*inflight_pairs) >= 2.
  - On issue: i1re=i2re=1, i1addr=pc, i2addr=pc+1, and pc advances by 2. Addition is mod 2^16, so 16'hFFFF wraps to 16'h0000.
- i1addr/i2addr always show pc and pc+1, combinationally from the pc register.
- Tracking pipe: MEM_LATENCY stages; each stage holds {valid, epoch, pc}.
  - The issuing cycle writes stage 0.
  - The pipe shifts on every gwe=1 cycle.
  - inflight_pairs is the number of valid stages.
- Return: when the final stage is valid and its epoch equals the current epoch, in that cycle:
  - push {pc, i1in} first;
  - push {pc+1, i2in} second.
  - Two entries are written in the same cycle. A mismatched epoch drops both words silently.
- Pop: out_valid = (fifo_count != 0). Pop occurs when out_valid & out_ready & gwe.
  - Push-2 and pop-1 in the same cycle is legal; fifo_count changes by +1.
  - Credit accounting guarantees no overflow. Overflow is a design error and the bench asserts on it.
- Redirect (gwe=1, redirect_valid=1) has priority over every other event in the cycle:
  - pc=redirect_pc, epoch toggles, FIFO cleared, fifo_count=0 next cycle.
  - No issue, no pop, and no push that cycle.
  - In-flight stages stay in the pipe but are tagged stale and dropped on return.
- out_valid after a redirect rises no earlier than MEM_LATENCY+1 cycles after the redirect cycle.
- Head update: out_insn/out_pc come from registered FIFO storage, so the value after a pop is visible next cycle. An empty FIFO holds the last values.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds a 32-bit stall_cycles counter, reset to 0.
  - Increments on each gwe=1 cycle with out_valid=0 and no redirect.
  - Saturates at 32'hFFFFFFFF.
  - Counting is not cleared by a redirect.
- Undefined: no stall_cycles port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset then straight-line fetch with MEM_LATENCY=1 and memory returning word=addr^16'hA5A5 → i1addr=8200/i2addr=8201 at first issue; out_valid rises 2 cycles after reset release; pops yield pc 8200,8201,8202,... with the matching words.
- Hold out_ready=0 with DEPTH=8 → issues stop with fifo_count=8 and no overflow; raise out_ready → one pop per cycle and fetch resumes once 2 slots free.
- Redirect to 16'h0100 while 3 pairs are in flight (MEM_LATENCY=3) → FIFO empty the next cycle; stale returns dropped; first popped out_pc=0100 and never 820x.
- Wrap-around: redirect_pc=16'hFFFE → popped pcs FFFE, FFFF, 0000, 0001.
- gwe pulsed 1-of-4 cycles during fetch → state advances only on gwe=1 cycles; out_ready with gwe=0 does not pop; output sequence is identical to the gwe=1 run.
- With FETCH_PERF_CNT_EN defined → stall_cycles=1 after the first post-reset cycle with MEM_LATENCY=1, and it stops counting while out_valid=1.
